// File: rtl/spike_rate_decoder.sv
// Spike-count rate decoder on the time-multiplexed neuron sweep: read-modify-write of per-neuron
// counts over a 2^WINDOW_LEN step window. Define DECODER_LEAKY_EN to halve counts at readout instead of clearing.
module spike_rate_decoder #(
  parameter int ACTIVITY_LEN = 9,
  parameter int ADDR_LEN     = 8,
  parameter int WINDOW_LEN   = 12,
  parameter int RATE_SHIFT   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dec_en,
  input  logic [ADDR_LEN-1:0]     dec_addr,
  input  logic                    spike_in,
  input  logic [ACTIVITY_LEN-1:0] state_in,
  input  logic                    step_done,
  output logic                    state_we,
  output logic [ADDR_LEN-1:0]     state_addr,
  output logic [ACTIVITY_LEN-1:0] state_out,
  output logic                    rate_valid,
  output logic [ADDR_LEN-1:0]     rate_addr,
  output logic [ACTIVITY_LEN-1:0] rate_out,
  output logic                    rate_sat,
  output logic                    win_last
);

  localparam int SHW = ACTIVITY_LEN + RATE_SHIFT;
  localparam logic [ACTIVITY_LEN-1:0] CNT_MAX  = '1;
  localparam logic [WINDOW_LEN-1:0]   STEP_ONE = WINDOW_LEN'(1);
  localparam logic [WINDOW_LEN-1:0]   STEP_LAST = '1;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_ACCUM,
    S_READOUT
  } state_t;

  state_t                  state_q;
  logic [WINDOW_LEN-1:0]   step_cnt_q;
  logic                    state_we_q;
  logic [ADDR_LEN-1:0]     state_addr_q;
  logic [ACTIVITY_LEN-1:0] state_out_q;
  logic                    rate_valid_q;
  logic [ADDR_LEN-1:0]     rate_addr_q;
  logic [ACTIVITY_LEN-1:0] rate_out_q;
  logic                    rate_sat_q;
  logic                    win_last_q;

  logic [ACTIVITY_LEN-1:0] base_d;
  logic [ACTIVITY_LEN:0]   sum_d;
  logic                    slot_sat_d;
  logic [ACTIVITY_LEN-1:0] cnt_d;
  logic [SHW-1:0]          shifted_d;
  logic                    shift_ovf_d;
  logic [ACTIVITY_LEN-1:0] rate_d;
  logic [ACTIVITY_LEN-1:0] readout_wr_d;
  logic [WINDOW_LEN-1:0]   step_inc_d;

  // Memory contents are untrusted until the CLEAR sweep has rewritten every neuron.
  always_comb begin
    base_d       = (state_q == S_CLEAR) ? '0 : state_in;
    sum_d        = {1'b0, base_d} + (ACTIVITY_LEN+1)'(spike_in);
    slot_sat_d   = sum_d[ACTIVITY_LEN];
    cnt_d        = slot_sat_d ? CNT_MAX : sum_d[ACTIVITY_LEN-1:0];
    shifted_d    = SHW'(cnt_d) << RATE_SHIFT;
    shift_ovf_d  = shifted_d > SHW'(CNT_MAX);
    rate_d       = shift_ovf_d ? CNT_MAX : shifted_d[ACTIVITY_LEN-1:0];
`ifdef DECODER_LEAKY_EN
    readout_wr_d = cnt_d >> 1;
`else
    readout_wr_d = '0;
`endif
    step_inc_d   = step_cnt_q + STEP_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      step_cnt_q   <= '0;
      state_we_q   <= 1'b0;
      state_addr_q <= '0;
      state_out_q  <= '0;
      rate_valid_q <= 1'b0;
      rate_addr_q  <= '0;
      rate_out_q   <= '0;
      rate_sat_q   <= 1'b0;
      win_last_q   <= 1'b0;
    end else begin
      state_we_q   <= dec_en;
      rate_valid_q <= 1'b0;
      if (dec_en) begin
        state_addr_q <= dec_addr;
        if (state_q == S_READOUT) begin
          state_out_q  <= readout_wr_d;
          rate_valid_q <= 1'b1;
          rate_addr_q  <= dec_addr;
          rate_out_q   <= rate_d;
          rate_sat_q   <= slot_sat_d | shift_ovf_d;
        end else begin
          state_out_q <= cnt_d;
        end
      end
      // A slot presented together with step_done still belongs to the ending step.
      if (step_done) begin
        case (state_q)
          S_CLEAR: begin
            step_cnt_q <= STEP_ONE;
            state_q    <= (STEP_ONE == STEP_LAST) ? S_READOUT : S_ACCUM;
            win_last_q <= (STEP_ONE == STEP_LAST);
          end
          S_ACCUM: begin
            step_cnt_q <= step_inc_d;
            if (step_inc_d == STEP_LAST) begin
              state_q    <= S_READOUT;
              win_last_q <= 1'b1;
            end
          end
          S_READOUT: begin
            step_cnt_q <= '0;
            state_q    <= S_ACCUM;
            win_last_q <= 1'b0;
          end
          default: begin
            step_cnt_q <= '0;
            state_q    <= S_CLEAR;
            win_last_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_we   = state_we_q;
  assign state_addr = state_addr_q;
  assign state_out  = state_out_q;
  assign rate_valid = rate_valid_q;
  assign rate_addr  = rate_addr_q;
  assign rate_out   = rate_out_q;
  assign rate_sat   = rate_sat_q;
  assign win_last   = win_last_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: two instances (RATE_SHIFT 0 and 10) share stimulus; a model
// pushes expected registered outputs per cycle and they are popped and checked one clock later.
`timescale 1ns/1ps
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       reset, dec_en, spike_in, step_done;
  logic [7:0] dec_addr;
  logic [8:0] state_in;

  logic       a_we, a_rv, a_rsat, a_wl;
  logic [7:0] a_addr, a_raddr;
  logic [8:0] a_sout, a_rout;
  logic       b_we, b_rv, b_rsat, b_wl;
  logic [7:0] b_addr, b_raddr;
  logic [8:0] b_sout, b_rout;

  always #5 clk = ~clk;

  spike_rate_decoder #(.ACTIVITY_LEN(9), .ADDR_LEN(8), .WINDOW_LEN(2), .RATE_SHIFT(0)) dut_a (
    .clk(clk), .reset(reset), .dec_en(dec_en), .dec_addr(dec_addr), .spike_in(spike_in),
    .state_in(state_in), .step_done(step_done), .state_we(a_we), .state_addr(a_addr),
    .state_out(a_sout), .rate_valid(a_rv), .rate_addr(a_raddr), .rate_out(a_rout),
    .rate_sat(a_rsat), .win_last(a_wl));

  spike_rate_decoder #(.ACTIVITY_LEN(9), .ADDR_LEN(8), .WINDOW_LEN(2), .RATE_SHIFT(10)) dut_b (
    .clk(clk), .reset(reset), .dec_en(dec_en), .dec_addr(dec_addr), .spike_in(spike_in),
    .state_in(state_in), .step_done(step_done), .state_we(b_we), .state_addr(b_addr),
    .state_out(b_sout), .rate_valid(b_rv), .rate_addr(b_raddr), .rate_out(b_rout),
    .rate_sat(b_rsat), .win_last(b_wl));

  typedef struct packed {
    logic       wl;
    logic       rsat_sh;
    logic [8:0] rout_sh;
    logic       rsat;
    logic [8:0] rout;
    logic [7:0] raddr;
    logic       rv;
    logic [8:0] sout;
    logic [7:0] addr;
    logic       we;
  } exp_t;

  exp_t       sbq[$];
  exp_t       held;
  int         m_state;  // 0 clear, 1 accum, 2 readout
  int         m_step;
  logic [8:0] mem [4];
  int         n_total = 0;
  int         n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model(input logic en, input logic [7:0] addr, input logic spike,
                       input logic [8:0] sin, input logic done, input logic rst);
    int base, sum, c, sh;
    bit sat;
    if (rst) begin
      held    = '0;
      m_state = 0;
      m_step  = 0;
    end else begin
      held.we = en;
      held.rv = 1'b0;
      if (en) begin
        base = (m_state == 0) ? 0 : int'(sin);
        sum  = base + int'(spike);
        sat  = (sum > 511);
        c    = sat ? 511 : sum;
        held.addr = addr;
        if (m_state == 2) begin
`ifdef DECODER_LEAKY_EN
          held.sout = 9'(c / 2);
`else
          held.sout = 9'd0;
`endif
          sh            = c * 1024;
          held.rv       = 1'b1;
          held.raddr    = addr;
          held.rout     = 9'(c);
          held.rsat     = sat;
          held.rout_sh  = (sh > 511) ? 9'd511 : 9'(sh);
          held.rsat_sh  = sat || (sh > 511);
        end else begin
          held.sout = 9'(c);
        end
        mem[addr[1:0]] = held.sout;
      end
      if (done) begin
        case (m_state)
          0: begin m_state = 1; m_step = 1; end
          1: begin m_step++; if (m_step == 3) m_state = 2; end
          default: begin m_state = 1; m_step = 0; end
        endcase
      end
    end
    held.wl = (m_state == 2);
  endtask

  task automatic step(input logic en, input logic [7:0] addr, input logic spike,
                      input logic [8:0] sin, input logic done, input logic rst);
    exp_t e;
    reset     = rst;
    dec_en    = en;
    dec_addr  = addr;
    spike_in  = spike;
    state_in  = sin;
    step_done = done;
    model(en, addr, spike, sin, done, rst);
    sbq.push_back(held);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    $display("cyc rst=%0b en=%0b addr=%0d spk=%0b done=%0b -> we=%0b sout=%0d rv=%0b rout=%0d/%0d wl=%0b",
             rst, en, addr, spike, done, a_we, a_sout, a_rv, a_rout, b_rout, a_wl);
    chk("state_we",      32'(a_we),    32'(e.we));
    chk("state_out",     32'(a_sout),  32'(e.sout));
    chk("rate_valid",    32'(a_rv),    32'(e.rv));
    chk("rate_out",      32'(a_rout),  32'(e.rout));
    chk("rate_sat",      32'(a_rsat),  32'(e.rsat));
    chk("win_last",      32'(a_wl),    32'(e.wl));
    chk("sh_state_out",  32'(b_sout),  32'(e.sout));
    chk("sh_rate_out",   32'(b_rout),  32'(e.rout_sh));
    chk("sh_rate_sat",   32'(b_rsat),  32'(e.rsat_sh));
    chk("sh_win_last",   32'(b_wl),    32'(e.wl));
    if (e.we) chk("state_addr", 32'(a_addr), 32'(e.addr));
    if (e.rv) chk("rate_addr",  32'(a_raddr), 32'(e.raddr));
  endtask

  // One full neuron sweep (step_done on the last slot) followed by an idle cycle.
  task automatic sweep(input logic [3:0] sp);
    logic [8:0] s;
    for (int n = 0; n < 4; n++) begin
      s = (m_state == 0) ? 9'bx : mem[n];
      step(1'b1, 8'(n), sp[n], s, (n == 3), 1'b0);
    end
    step(1'b0, 8'd0, 1'b0, 9'd0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 9'd0;
    held = '0; m_state = 0; m_step = 0;
    reset = 1'b1; dec_en = 1'b0; dec_addr = '0; spike_in = 1'b0; state_in = '0; step_done = 1'b0;

    step(1'b0, 8'd0, 1'b0, 9'd0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 9'd0, 1'b0, 1'b1);

    // Window 1: CLEAR sweep with unknown memory, then two ACCUM steps and READOUT.
    sweep(4'b0010);
    sweep(4'b0000);
    sweep(4'b0000);
    sweep(4'b0000);

    // Window 2: n2 spikes in every step.
    sweep(4'b0100);
    sweep(4'b0100);
    sweep(4'b0100);
    sweep(4'b0100);

    // Window 3: saturation, empty step, shift overflow, and a count of 7 at readout.
    mem[0] = 9'd511;
    sweep(4'b0001);
    step(1'b0, 8'd0, 1'b0, 9'd0, 1'b1, 1'b0);
    sweep(4'b0000);
    mem[2] = 9'd6;
    sweep(4'b0111);

    // Window 4: reset during a slot at step 2, then a fresh window from CLEAR.
    sweep(4'b1001);
    sweep(4'b0011);
    step(1'b1, 8'd0, 1'b1, mem[0], 1'b0, 1'b0);
    step(1'b1, 8'd1, 1'b1, mem[1], 1'b0, 1'b1);
    sweep(4'b1111);
    sweep(4'b1010);
    sweep(4'b0101);
    sweep(4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
